// File: rtl/ha_pkg.sv
// Shared types and sizing helpers for the half_adder result packer.
// The carry-count and length fields are sized by ha_cw so they can hold the value W itself.
package ha_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } packer_state_t;

  localparam int HA_PACK_W = 4;

  function automatic int ha_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ha_out_reg.sv
// Single-entry valid/ready holding register.
// It can be popped and reloaded on the same edge without a bubble.
module ha_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_i,
  input  logic          ready_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic          free_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // next-state: a load wins over a pop; a bare pop keeps the stale payload
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // holding register state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign free_o  = !valid_q || ready_i;
  assign data_o  = data_q;

endmodule

// File: rtl/ha_result_packer.sv
// Packs W consecutive half_adder (sum, carry) results into one word with a popcount of carries.
// A collect buffer plus ha_out_reg let the next word fill while the current one waits.
module ha_result_packer
  import ha_pkg::*;
#(
  parameter int W = HA_PACK_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sum,
  input  logic                   in_carry,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_word,
  output logic [ha_cw(W)-1:0]    out_carries,
  output logic [ha_cw(W)-1:0]    out_len
);

  localparam int CW = ha_cw(W);
  localparam int DW = W + 2 * CW;

  packer_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  bits_q, bits_d;
  logic [CW-1:0] carries_q, carries_d;

  logic          accept_s;
  logic          complete_s;
  logic          load_s;
  logic          out_free_s;
  logic [CW-1:0] len_s;
  logic [W-1:0]  bits_s;
  logic [CW-1:0] carries_s;
  logic [DW-1:0] load_data_s;
  logic [DW-1:0] out_data_s;

  assign in_ready = (state_q == COLLECT);

  // collect/FULL control; a completed word goes straight to the output reg when it is free
  always_comb begin
    accept_s    = in_valid && (state_q == COLLECT);
    len_s       = cnt_q + CW'(accept_s);
    bits_s      = bits_q;
    for (int i = 0; i < W; i++) begin
      if (accept_s && (cnt_q == CW'(i))) begin
        bits_s[i] = in_sum;
      end else begin
        bits_s[i] = bits_q[i];
      end
    end
    carries_s   = carries_q + CW'(accept_s && in_carry);
    complete_s  = 1'b0;
    load_s      = 1'b0;
    load_data_s = {len_s, carries_s, bits_s};
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    carries_d   = carries_q;

    case (state_q)
      COLLECT: begin
        complete_s = (accept_s && (len_s == CW'(W))) || (flush && (len_s != '0));
        if (complete_s) begin
          if (out_free_s) begin
            load_s    = 1'b1;
            cnt_d     = '0;
            bits_d    = '0;
            carries_d = '0;
          end else begin
            state_d   = FULL;
            cnt_d     = len_s;
            bits_d    = bits_s;
            carries_d = carries_s;
          end
        end else if (accept_s) begin
          cnt_d     = len_s;
          bits_d    = bits_s;
          carries_d = carries_s;
        end else begin
          cnt_d     = cnt_q;
        end
      end
      FULL: begin
        load_data_s = {cnt_q, carries_q, bits_q};
        if (out_free_s) begin
          load_s    = 1'b1;
          state_d   = COLLECT;
          cnt_d     = '0;
          bits_d    = '0;
          carries_d = '0;
        end else begin
          state_d   = FULL;
        end
      end
      default: begin
        state_d   = COLLECT;
        cnt_d     = '0;
        bits_d    = '0;
        carries_d = '0;
      end
    endcase
  end

  // collect buffer, counter and FSM state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      bits_q    <= '0;
      carries_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      carries_q <= carries_d;
    end
  end

  ha_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (load_s),
    .ready_i (out_ready),
    .data_i  (load_data_s),
    .valid_o (out_valid),
    .free_o  (out_free_s),
    .data_o  (out_data_s)
  );

  assign out_word    = out_data_s[W-1:0];
  assign out_carries = out_data_s[W+CW-1:W];
  assign out_len     = out_data_s[DW-1:W+CW];

endmodule
